// File: rtl/datapath_pipe_if.sv
// Instruction/result bundle between the lab controller (master) and datapath_pipe (slave).
interface datapath_pipe_if #(
    parameter int WIDTH = 17,
    parameter int AW    = 4
);
    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       op;
    logic [AW-1:0]    src1;
    logic [AW-1:0]    src2;
    logic [AW-1:0]    dest;
    logic [WIDTH-1:0] ext_data1;
    logic [WIDTH-1:0] ext_data2;
    logic [WIDTH-1:0] outreg_data;
    logic             overflow;
    logic             wr_done;
    logic             busy;

    modport master (
        output instr_valid, op, src1, src2, dest, ext_data1, ext_data2,
        input  instr_ready, outreg_data, overflow, wr_done, busy
    );

    modport slave (
        input  instr_valid, op, src1, src2, dest, ext_data1, ext_data2,
        output instr_ready, outreg_data, overflow, wr_done, busy
    );
endinterface

// File: rtl/datapath_pipe.sv
// Register file + ALU + R0 output register with a valid/ready instruction port
// and an iterative shift-add multiplier.
// Build option: DP_MUL_FAST_EN selects a single-cycle combinational multiplier
// (no stall, busy tied low); undefined gives the WIDTH-cycle iterative one.
//
// state  | meaning
// S_IDLE | accepting instructions, non-MUL ops commit on the acceptance edge
// S_MUL  | shift-add multiply in progress, instr_ready low, no issue
module datapath_pipe #(
    parameter int WIDTH = 17,
    parameter int NREGS = 16
) (
    input logic            clk,
    input logic            rst,
    datapath_pipe_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

    localparam logic [2:0] OP_COPY  = 3'b001;
    localparam logic [2:0] OP_LOAD1 = 3'b010;
    localparam logic [2:0] OP_LOAD2 = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_MUL   = 3'b111;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    logic [WIDTH-1:0]   r_regs [NREGS];
    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [AW-1:0]      r_dest;
    logic [CW-1:0]      r_cnt;
    logic               r_ovf;
    logic               r_wr_done;
    logic [WIDTH-1:0]   r_outreg;

    logic [WIDTH-1:0]   w_rd1;
    logic [WIDTH-1:0]   w_rd2;
    logic               w_accept;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH:0]     w_mul_step;
    logic [2*WIDTH-1:0] w_prod_next;
    logic               w_wr_en;
    logic [AW-1:0]      w_wr_addr;
    logic [WIDTH-1:0]   w_wr_data;
    logic               w_ovf_upd;
    logic               w_ovf_val;
    logic               w_start_mul;
`ifdef DP_MUL_FAST_EN
    logic [2*WIDTH-1:0] w_full;
    assign w_full = {{WIDTH{1'b0}}, w_rd1} * {{WIDTH{1'b0}}, w_rd2};
`endif

    // Combinational register reads; indices beyond the file read as zero.
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if ({1'b0, bus.src1} < NREGS_W) w_rd1 = r_regs[bus.src1];
        if ({1'b0, bus.src2} < NREGS_W) w_rd2 = r_regs[bus.src2];
    end

    assign w_accept    = bus.instr_valid && (r_state == S_IDLE);
    assign w_sum       = {1'b0, w_rd1} + {1'b0, w_rd2};
    assign w_diff      = {1'b0, w_rd1} - {1'b0, w_rd2};
    // One multiplier bit per cycle: add multiplicand into the upper half, then shift right.
    assign w_mul_step  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_next = {w_mul_step, r_prod[WIDTH-1:1]};

    // Single write port: either the finishing multiply or the op accepted this cycle.
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_addr   = bus.dest;
        w_wr_data   = '0;
        w_ovf_upd   = 1'b0;
        w_ovf_val   = 1'b0;
        w_start_mul = 1'b0;
        if (r_state == S_MUL) begin
            if (r_cnt == '0) begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_dest;
                w_wr_data = w_prod_next[2*WIDTH-1:WIDTH];
                w_ovf_upd = 1'b1;
            end
        end else if (w_accept) begin
            case (bus.op)
                OP_COPY: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = w_rd1;
                end
                OP_LOAD1: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = bus.ext_data1;
                end
                OP_LOAD2: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = bus.ext_data2;
                end
                OP_ADD: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = w_sum[WIDTH-1:0];
                    w_ovf_upd = 1'b1;
                    w_ovf_val = w_sum[WIDTH];
                end
                OP_SUB: begin
                    w_wr_en   = 1'b1;
                    w_wr_data = w_diff[WIDTH-1:0];
                    w_ovf_upd = 1'b1;
                    w_ovf_val = w_diff[WIDTH];
                end
                OP_MUL: begin
`ifdef DP_MUL_FAST_EN
                    w_wr_en   = 1'b1;
                    w_wr_data = w_full[2*WIDTH-1:WIDTH];
                    w_ovf_upd = 1'b1;
`else
                    w_start_mul = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // Register file; writes to indices beyond the file are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wr_en && ({1'b0, w_wr_addr} < NREGS_W)) begin
            r_regs[w_wr_addr] <= w_wr_data;
        end
    end

    // Multiply FSM plus registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_prod    <= '0;
            r_dest    <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_wr_done <= 1'b0;
            r_outreg  <= '0;
        end else begin
            r_wr_done <= w_wr_en;
            if (w_wr_en && (w_wr_addr == '0)) r_outreg <= w_wr_data;
            if (w_ovf_upd) r_ovf <= w_ovf_val;
            case (r_state)
                S_IDLE: begin
                    if (w_start_mul) begin
                        r_state <= S_MUL;
                        r_mcand <= w_rd1;
                        r_prod  <= {{WIDTH{1'b0}}, w_rd2};
                        r_dest  <= bus.dest;
                        r_cnt   <= CW'(WIDTH - 1);
                    end
                end
                S_MUL: begin
                    r_prod <= w_prod_next;
                    if (r_cnt == '0) r_state <= S_IDLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_ready = (r_state == S_IDLE);
`ifdef DP_MUL_FAST_EN
    assign bus.busy        = 1'b0;
`else
    assign bus.busy        = (r_state == S_MUL);
`endif
    assign bus.outreg_data = r_outreg;
    assign bus.overflow    = r_ovf;
    assign bus.wr_done     = r_wr_done;
endmodule

// File: tb/tb_datapath_pipe.sv
// Scoreboard bench for datapath_pipe: an ISA-level register model predicts
// overflow and outreg_data for every commit; register contents are observed
// by copying them into R0.
module tb_datapath_pipe;
    localparam int W  = 17;
    localparam int NR = 16;
    localparam int AW = 4;
`ifdef DP_MUL_FAST_EN
    localparam int MUL_LOW = 0;
`else
    localparam int MUL_LOW = W;
`endif

    typedef struct packed {
        logic         ovf;
        logic [W-1:0] outv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    datapath_pipe_if #(.WIDTH(W), .AW(AW)) dp_if ();

    datapath_pipe #(.WIDTH(W), .NREGS(NR)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dp_if.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] m_regs [NR];
    logic         m_ovf;
    logic [W-1:0] m_out;
    exp_t         sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_ovf = 1'b0;
        m_out = '0;
        sb.delete();
    endtask

    // Architectural effect of one accepted instruction, in program order.
    task automatic model_exec(input logic [2:0] op, input int s1, input int s2, input int d,
                              input logic [W-1:0] e1, input logic [W-1:0] e2);
        logic [W-1:0] a, b, v;
        logic [63:0]  p;
        logic         wr;
        a  = m_regs[s1];
        b  = m_regs[s2];
        v  = '0;
        wr = 1'b1;
        case (op)
            3'b001: v = a;
            3'b010: v = e1;
            3'b011: v = e2;
            3'b100: begin
                p = 64'(a) + 64'(b);
                v = p[W-1:0];
                m_ovf = p[W];
            end
            3'b110: begin
                v = a - b;
                m_ovf = (a < b);
            end
            3'b111: begin
                p = 64'(a) * 64'(b);
                v = W'(p >> W);
                m_ovf = 1'b0;
            end
            default: wr = 1'b0;
        endcase
        if (wr) begin
            m_regs[d] = v;
            if (d == 0) m_out = v;
            sb.push_back('{ovf: m_ovf, outv: m_out});
        end
    endtask

    // Present an instruction, hold it until accepted, return at the following negedge.
    task automatic issue(input logic [2:0] op, input int s1, input int s2, input int d,
                         input logic [W-1:0] e1 = '0, input logic [W-1:0] e2 = '0);
        int n;
        dp_if.op          = op;
        dp_if.src1        = AW'(s1);
        dp_if.src2        = AW'(s2);
        dp_if.dest        = AW'(d);
        dp_if.ext_data1   = e1;
        dp_if.ext_data2   = e2;
        dp_if.instr_valid = 1'b1;
        n = 0;
        while (!dp_if.instr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("issue_timeout", 32'(n), 32'd0);
        @(posedge clk);
        model_exec(op, s1, s2, d, e1, e2);
        @(negedge clk);
        dp_if.instr_valid = 1'b0;
    endtask

    task automatic mul_timed(input string tag, input int s1, input int s2, input int d);
        int lo;
        issue(3'b111, s1, s2, d);
        lo = 0;
        while (!dp_if.instr_ready && lo < 100) begin
            lo++;
            @(negedge clk);
        end
        check(tag, 32'(lo), 32'(MUL_LOW));
    endtask

    task automatic show(input int r);
        issue(3'b001, r, 0, 0);
    endtask

    // Commit monitor: every wr_done pulse must match the oldest predicted commit.
    always @(negedge clk) begin
        if (!rst && dp_if.wr_done) begin
            if (sb.size() == 0) begin
                check("spurious_wr_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("overflow", 32'(dp_if.overflow), 32'(e.ovf));
                check("outreg_data", 32'(dp_if.outreg_data), 32'(e.outv));
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb;
        dp_if.instr_valid = 1'b0;
        dp_if.op          = '0;
        dp_if.src1        = '0;
        dp_if.src2        = '0;
        dp_if.dest        = '0;
        dp_if.ext_data1   = '0;
        dp_if.ext_data2   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_outreg", 32'(dp_if.outreg_data), 32'd0);
        check("rst_overflow", 32'(dp_if.overflow), 32'd0);
        check("rst_wr_done", 32'(dp_if.wr_done), 32'd0);
        check("rst_busy", 32'(dp_if.busy), 32'd0);
        check("rst_ready", 32'(dp_if.instr_ready), 32'd1);

        // Loads and copy
        issue(3'b010, 0, 0, 1, W'(25), '0);
        issue(3'b011, 0, 0, 2, '0, W'(12));
        issue(3'b001, 1, 0, 3);
        show(1); show(2); show(3);

        // ADD/SUB and a back-to-back dependent ADD
        issue(3'b100, 1, 2, 4);
        issue(3'b110, 1, 2, 5);
        issue(3'b100, 4, 1, 6);
        show(4); show(5); show(6);

        // NOP and reserved opcode: no commit expected
        issue(3'b000, 1, 2, 7);
        issue(3'b101, 1, 2, 7);

        // Multiplies
        mul_timed("mul_ready_low_small", 1, 2, 7);
        show(7);
        issue(3'b010, 0, 0, 8, W'(17'h1FFFF), '0);
        mul_timed("mul_ready_low_max", 8, 8, 13);
        show(13);
        ra = W'($urandom);
        rb = W'($urandom);
        issue(3'b010, 0, 0, 14, ra, '0);
        issue(3'b011, 0, 0, 15, '0, rb);
        mul_timed("mul_ready_low_rand", 14, 15, 12);
        show(12);

        // Overflow and borrow, then COPY keeps the flag
        issue(3'b010, 0, 0, 9, W'(1), '0);
        issue(3'b100, 8, 9, 10);
        issue(3'b110, 9, 8, 11);
        show(10); show(11);

        // MUL then an instruction held while busy: accepted exactly once
        issue(3'b111, 1, 2, 14);
        issue(3'b010, 0, 0, 15, W'(5), '0);
        show(15); show(14);

        // R0 write is reflected on outreg_data
        issue(3'b001, 4, 0, 0);

        // Reset in the middle of a multiply
        issue(3'b010, 0, 0, 12, W'(99), '0);
        issue(3'b111, 4, 4, 12);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midmul_rst_outreg", 32'(dp_if.outreg_data), 32'd0);
        check("midmul_rst_overflow", 32'(dp_if.overflow), 32'd0);
        check("midmul_rst_ready", 32'(dp_if.instr_ready), 32'd1);
        check("midmul_rst_busy", 32'(dp_if.busy), 32'd0);
        check("midmul_rst_wr_done", 32'(dp_if.wr_done), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_ready", 32'(dp_if.instr_ready), 32'd1);
        show(12); show(4);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1);
    end
endmodule
